// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - note codes, song ROM and 50 MHz tone half-period table
package music_pkg;

   typedef enum logic [4:0] {
      REST,
      L1, L2, L3, L4, L5, L6, L7,
      M1, M2, M3, M4, M5, M6, M7,
      H1, H2, H3, H4, H5, H6, H7
   } note_e;

   localparam int unsigned NOTE_MAX = 21;

   // Row index is music_reg; row 0 is the mute row and stays all rests.
   localparam note_e SONG_ROM [0:3][0:31] = '{
      '{default: REST},
      '{M1, M1, M5, M5, M6, M6, M5, REST, M4, M4, M3, M3, M2, M2, M1, REST,
        M5, M5, M4, M4, M3, M3, M2, REST, M5, M5, M4, M4, M3, M3, M2, REST},
      '{M3, M5, REST, H1, M6, M5, M3, M2, M1, M2, M3, M5, M3, M2, M1, REST,
        L6, L5, L6, M1, M2, M3, M2, M1, L6, L5, L6, M1, M2, REST, M1, REST},
      '{H7, H7, H7, H7, H6, H5, H4, H3, H2, H1, M7, M6, M5, M4, M3, M2,
        M1, L7, L6, L5, L4, L3, L2, L1, L1, L3, L5, M1, M3, M5, H1, REST}
   };

   localparam logic [17:0] HALF_PER [0:21] = '{
      18'd0,
      18'd95420, 18'd85034, 18'd75758, 18'd71633, 18'd63776, 18'd56818, 18'd50607,
      18'd47801, 18'd42589, 18'd37936, 18'd35817, 18'd31888, 18'd28409, 18'd25304,
      18'd23878, 18'd21277, 18'd18954, 18'd17896, 18'd15944, 18'd14205, 18'd12652
   };

   // Scaled half-period, never below one cycle so the tone counter always wraps.
   function automatic logic [17:0] tone_half(input logic [4:0] code, input int unsigned shift);
      logic [17:0] h;
      h = (code <= 5'(NOTE_MAX)) ? (HALF_PER[code] >> shift) : 18'd0;
      return (h == 18'd0) ? 18'd1 : h;
   endfunction

endpackage

// File: rtl/tone_gen.sv
// rtl/tone_gen.sv - buzzer square wave from the registered note code, with pause hold
module tone_gen
   import music_pkg::*;
#(
   parameter int unsigned TONE_SHIFT = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       hold,
   input  logic [4:0] note_code,
   output logic       beep
);

   logic [17:0] cnt;
   logic [17:0] eff_cnt;
   logic [17:0] half;
   logic [4:0]  prev_code;

   // A new note restarts its half-period in the very cycle it appears.
   always_comb begin
      half    = tone_half(note_code, TONE_SHIFT);
      eff_cnt = (note_code != prev_code) ? 18'd0 : cnt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= 18'd0;
         beep      <= 1'b0;
         prev_code <= 5'd0;
      end else begin
         prev_code <= note_code;
         if (note_code == REST) begin
            cnt  <= 18'd0;
            beep <= 1'b0;
         end else if (clr) begin
            cnt <= 18'd0;
            if (hold)
               beep <= 1'b0;
         end else if (hold) begin
            cnt  <= eff_cnt;
            beep <= 1'b0;
         end else if (eff_cnt == half - 18'd1) begin
            cnt  <= 18'd0;
            beep <= ~beep;
         end else begin
            cnt <= eff_cnt + 18'd1;
         end
      end
   end

endmodule

// File: rtl/music_note_seq.sv
// rtl/music_note_seq.sv - beat/note playback sequencer driving the buzzer
// Defining MUSIC_PAUSE_EN adds a pause input that freezes playback.
module music_note_seq
   import music_pkg::*;
#(
   parameter int unsigned BEAT_CYC   = 12_500_000,
   parameter int unsigned SONG_LEN   = 32,
   parameter int unsigned TONE_SHIFT = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] music_reg,
   input  logic       cnt_clc,
`ifdef MUSIC_PAUSE_EN
   input  logic       pause,
`endif
   output logic [4:0] note_idx,
   output logic [4:0] note_code,
   output logic       beat_tick,
   output logic       song_done,
   output logic       beep
);

   localparam int unsigned      BEAT_W    = $clog2(BEAT_CYC);
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYC - 1);
   localparam logic [4:0]        IDX_LAST  = 5'(SONG_LEN - 1);

   logic [BEAT_W-1:0] beat_cnt;
   logic              hold;

`ifdef MUSIC_PAUSE_EN
   assign hold = pause;
`else
   assign hold = 1'b0;
`endif

   // Restart and mute both pin the position at note 0; restart wins over a terminal count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt  <= '0;
         note_idx  <= 5'd0;
         note_code <= 5'd0;
         beat_tick <= 1'b0;
         song_done <= 1'b0;
      end else begin
         note_code <= SONG_ROM[music_reg][note_idx];
         beat_tick <= 1'b0;
         song_done <= 1'b0;
         if (cnt_clc || music_reg == 2'd0) begin
            beat_cnt <= '0;
            note_idx <= 5'd0;
         end else if (!hold) begin
            if (beat_cnt == BEAT_LAST) begin
               beat_cnt  <= '0;
               beat_tick <= 1'b1;
               if (note_idx == IDX_LAST) begin
                  note_idx  <= 5'd0;
                  song_done <= 1'b1;
               end else begin
                  note_idx <= note_idx + 5'd1;
               end
            end else begin
               beat_cnt <= beat_cnt + BEAT_W'(1);
            end
         end
      end
   end

   tone_gen #(
      .TONE_SHIFT (TONE_SHIFT)
   ) u_tone (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (cnt_clc),
      .hold      (hold),
      .note_code (note_code),
      .beep      (beep)
   );

endmodule

// File: tb/tb_music_note_seq.sv
// tb/tb_music_note_seq.sv - self-checking bench for music_note_seq against a beat-count model
module tb_music_note_seq;
   import music_pkg::*;

   localparam int BC = 4;
   localparam int SL = 4;
   localparam int TS = 12;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] music_reg;
   logic       cnt_clc;
   logic       pause;
   logic [4:0] note_idx;
   logic [4:0] note_code;
   logic       beat_tick;
   logic       song_done;
   logic       beep;

   int checks = 0;
   int errors = 0;

   // Model: position is a count of played cycles since the last restart/mute.
   int         run, t, anchor;
   logic [4:0] m_idx, m_code, m_prev;
   logic       m_tick, m_done, m_beep;

   always #5 clk = ~clk;

   music_note_seq #(
      .BEAT_CYC   (BC),
      .SONG_LEN   (SL),
      .TONE_SHIFT (TS)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .music_reg (music_reg),
      .cnt_clc   (cnt_clc),
`ifdef MUSIC_PAUSE_EN
      .pause     (pause),
`endif
      .note_idx  (note_idx),
      .note_code (note_code),
      .beat_tick (beat_tick),
      .song_done (song_done),
      .beep      (beep)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      run = 0; t = 0; anchor = 0;
      m_idx = 5'd0; m_code = 5'd0; m_prev = 5'd0;
      m_tick = 1'b0; m_done = 1'b0; m_beep = 1'b0;
   endtask

   task automatic model_edge();
      logic [4:0] nxt_code;
      int hp;
      nxt_code = SONG_ROM[music_reg][m_idx];
      if (cnt_clc || music_reg == 2'd0) begin
         run = 0; m_tick = 1'b0; m_done = 1'b0;
      end else if (pause) begin
         m_tick = 1'b0; m_done = 1'b0;
      end else begin
         run++;
         m_tick = (run % BC == 0);
         m_done = m_tick && ((run / BC) % SL == 0);
      end
      m_idx = 5'((run / BC) % SL);
      hp = int'(HALF_PER[m_code] >> TS);
      if (hp == 0) hp = 1;
      if (m_code == 5'd0) begin
         m_beep = 1'b0;
      end else if (cnt_clc) begin
         anchor = t;
         if (pause) m_beep = 1'b0;
      end else begin
         if (m_code != m_prev) anchor = t - 1;
         if (pause) begin
            anchor++;
            m_beep = 1'b0;
         end else if ((t - anchor) % hp == 0) begin
            m_beep = ~m_beep;
         end
      end
      m_prev = m_code;
      m_code = nxt_code;
      t++;
   endtask

   task automatic check_outputs();
      check("note_idx",  32'(note_idx),  32'(m_idx));
      check("note_code", 32'(note_code), 32'(m_code));
      check("beat_tick", 32'(beat_tick), 32'(m_tick));
      check("song_done", 32'(song_done), 32'(m_done));
      check("beep",      32'(beep),      32'(m_beep));
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_idx"},  32'(note_idx),  32'd0);
      check({tag, "_code"}, 32'(note_code), 32'd0);
      check({tag, "_tick"}, 32'(beat_tick), 32'd0);
      check({tag, "_done"}, 32'(song_done), 32'd0);
      check({tag, "_beep"}, 32'(beep),      32'd0);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      model_edge();
      check_outputs();
   endtask

   initial begin
      int done_cnt, last_rise, exp_per;
      logic prev_beep;
      logic [4:0] frozen_idx;

      rst_n = 1'b1; music_reg = 2'd1; cnt_clc = 1'b0; pause = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_zero("rst_async");
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_zero("rst_hold");
      rst_n = 1'b1;
      model_reset();

      // first beat after release, then a full song pass
      done_cnt = 0;
      for (int i = 1; i <= 16; i++) begin
         step();
         done_cnt += int'(song_done);
         if (i == 4) begin
            check("first_tick", 32'(beat_tick), 32'd1);
            check("first_idx",  32'(note_idx),  32'd1);
         end
      end
      check("done_once", 32'(done_cnt), 32'd1);

      // restart mid-beat at note 2
      repeat (9) step();
      check("pre_clr_idx", 32'(note_idx), 32'd2);
      cnt_clc = 1'b1;
      step();
      cnt_clc = 1'b0;
      check("clr_idx",  32'(note_idx),  32'd0);
      check("clr_tick", 32'(beat_tick), 32'd0);
      repeat (3) step();
      check("clr_tick_early", 32'(beat_tick), 32'd0);
      step();
      check("clr_tick_4", 32'(beat_tick), 32'd1);

      // restart coincident with terminal count
      repeat (3) step();
      cnt_clc = 1'b1;
      step();
      cnt_clc = 1'b0;
      check("tc_clr_tick", 32'(beat_tick), 32'd0);
      check("tc_clr_idx",  32'(note_idx),  32'd0);
      repeat (4) step();

      // mute, then switch to song 2 with restart
      music_reg = 2'd0;
      step();
      check("mute_code", 32'(note_code), 32'd0);
      repeat (8) step();
      check("mute_beep", 32'(beep), 32'd0);
      music_reg = 2'd2; cnt_clc = 1'b1;
      step();
      cnt_clc = 1'b0;
      step();
      check("song2_code", 32'(note_code), 32'(SONG_ROM[2][0]));
      repeat (10) step();

      // constant note: measure beep period
      music_reg = 2'd3; cnt_clc = 1'b1;
      step();
      cnt_clc = 1'b0;
      exp_per = int'(HALF_PER[SONG_ROM[3][0]] >> TS);
      if (exp_per == 0) exp_per = 1;
      exp_per = 2 * exp_per;
      last_rise = -1;
      prev_beep = beep;
      for (int i = 0; i < 40; i++) begin
         step();
         if (beep && !prev_beep) begin
            if (last_rise >= 0) check("beep_period", 32'(i - last_rise), 32'(exp_per));
            last_rise = i;
         end
         prev_beep = beep;
      end
      check("beep_seen", 32'(last_rise >= 0), 32'd1);

`ifdef MUSIC_PAUSE_EN
      frozen_idx = m_idx;
      pause = 1'b1;
      repeat (10) step();
      check("pause_idx",  32'(note_idx), 32'(frozen_idx));
      check("pause_beep", 32'(beep),     32'd0);
      pause = 1'b0;
      step();
      check("resume_idx", 32'(note_idx), 32'(frozen_idx));
      repeat (8) step();
`else
      frozen_idx = 5'd0;
      check("nopause_frozen", 32'(frozen_idx), 32'(note_idx & 5'd0));
`endif

      // randomized playback
      for (int i = 0; i < 400; i++) begin
         cnt_clc = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 31) == 0) music_reg = 2'($urandom_range(0, 3));
`ifdef MUSIC_PAUSE_EN
         if ($urandom_range(0, 19) == 0) pause = ~pause;
`endif
         step();
      end
      cnt_clc = 1'b0;
      pause = 1'b0;

      // asynchronous reset in the middle of a beat
      music_reg = 2'd1;
      repeat (6) step();
      #2 rst_n = 1'b0;
      #1 check_zero("rst_mid");
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (20) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
